ahb_lite_mem_slave: RTL and testbench

AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

---
 rtl/ahb_lite_mem_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_mem_slave
// Brief    : AHB-Lite memory slave with byte-lane writes, registered reads,
//            read-after-write forwarding and a two-cycle ERROR response.
//            Optional wait states are enabled by defining WAIT_STATE_EN; each
//            valid transfer then stalls for WAIT_CYCLES cycles before its
//            data phase completes.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_mem_slave #(
  parameter int data_size   = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 H_clk,
  input  logic                 H_rstN,
  input  logic                 H_sel,
  input  logic [31:0]          H_add,
  input  logic                 H_WR,
  input  logic [2:0]           H_size,
  input  logic [3:0]           H_burst,
  input  logic [1:0]           H_trans,
  input  logic [data_size-1:0] W_data,
  output logic [data_size-1:0] R_data,
  output logic                 H_readyN,
  output logic                 H_rsp
);

  // Word index width; a single-word memory still needs one index bit.
  localparam int c_ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef WAIT_STATE_EN
  // WAIT_CYCLES of zero collapses to the zero-wait-state behaviour.
  localparam bit c_WAIT_EN = (WAIT_CYCLES > 0);
  localparam int c_CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST =
      (WAIT_CYCLES > 0) ? c_CNT_W'(WAIT_CYCLES - 1) : '0;
`else
  localparam bit c_WAIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Storage is deliberately left out of reset.
  logic [data_size-1:0] r_mem [MEM_DEPTH];

  // Captured address-phase information for the transfer in its data phase.
  logic [c_ADDR_W-1:0]  r_idx;
  logic                 r_wr;
  logic [3:0]           r_be;
  logic [data_size-1:0] r_rdata;

  logic                 w_ready;
  logic                 w_rsp;
  logic                 w_sample;
  logic                 w_err;
  logic                 w_range_err;
  logic                 w_size_err;
  logic                 w_align_err;
  logic                 w_commit;
  logic                 w_fwd;
  logic [c_ADDR_W-1:0]  w_idx;
  logic [3:0]           w_be;
  logic [data_size-1:0] w_rd_word;
  logic                 w_unused;

`ifdef WAIT_STATE_EN
  logic [c_CNT_W-1:0]   r_wait_cnt;
`endif

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  assign w_idx       = H_add[c_ADDR_W+1:2];
  assign w_range_err = ({2'b00, H_add[31:2]} >= 32'(MEM_DEPTH));
  assign w_size_err  = (H_size > 3'b010);
  assign w_align_err = ((H_size == 3'b001) && H_add[0]) ||
                       ((H_size == 3'b010) && (H_add[1:0] != 2'b00));
  assign w_err       = w_range_err || w_size_err || w_align_err;

  // Byte-lane enables for the incoming transfer (little-endian lanes).
  always_comb begin
    w_be = 4'b0000;
    case (H_size)
      3'b000:  w_be = 4'b0001 << H_add[1:0];
      3'b001:  w_be = H_add[1] ? 4'b1100 : 4'b0011;
      3'b010:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // Advance the transfer state; reset aborts whatever is in flight.
  always_ff @(posedge H_clk) begin
    if (!H_rstN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and bus outputs
  // --------------------------------------------------------------------------
  // Outputs are a pure function of state; a new address phase is only
  // accepted while the slave is showing ready.
  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b1;
    w_rsp    = 1'b0;
    w_sample = 1'b0;

    case (r_state)
      ST_WAIT: w_ready = 1'b0;
      ST_ERR1: begin
        w_ready = 1'b0;
        w_rsp   = 1'b1;
      end
      ST_ERR2: w_rsp = 1'b1;
      default: ;
    endcase

    // H_trans[1] set means NONSEQ or SEQ; IDLE and BUSY are ignored.
    w_sample = w_ready && H_sel && H_trans[1];

    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_sample) begin
          if (w_err) begin
            w_next = ST_ERR1;
          end else if (c_WAIT_EN) begin
            w_next = ST_WAIT;
          end else begin
            w_next = ST_DATA;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ERR1: w_next = ST_ERR2;
`ifdef WAIT_STATE_EN
      ST_WAIT: w_next = (r_wait_cnt == c_WAIT_LAST) ? ST_DATA : ST_WAIT;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef WAIT_STATE_EN
  // --------------------------------------------------------------------------
  // Wait-state counter
  // --------------------------------------------------------------------------
  // Counts cycles spent in WAIT; restarts from zero on every entry.
  always_ff @(posedge H_clk) begin
    if (!H_rstN) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Write commit and read-after-write forwarding
  // --------------------------------------------------------------------------
  // A write lands on the edge that ends its data phase; reset on that edge
  // suppresses it so an aborted transfer leaves memory untouched.
  assign w_commit = H_rstN && (r_state == ST_DATA) && r_wr;

  // A read sampled on the commit edge of a write to the same word must see
  // the lanes being written this very edge.
  assign w_fwd = w_commit && (r_idx == w_idx);

  // Merge the completing write's lanes over the stored word when forwarding.
  always_comb begin
    w_rd_word = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_fwd && r_be[i]) begin
        w_rd_word[8*i +: 8] = W_data[8*i +: 8];
      end
    end
  end

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge H_clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[r_idx][8*i +: 8] <= W_data[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Address capture and read data register
  // --------------------------------------------------------------------------
  // Latch the accepted transfer; reads register the full word at the
  // sampling edge so R_data is stable for the whole data phase, and an
  // errored transfer drives zero.
  always_ff @(posedge H_clk) begin
    if (!H_rstN) begin
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_be    <= 4'b0000;
      r_rdata <= '0;
    end else if (w_sample) begin
      r_idx <= w_idx;
      r_be  <= w_be;
      r_wr  <= H_WR && !w_err;
      if (w_err) begin
        r_rdata <= '0;
      end else if (!H_WR) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign R_data   = r_rdata;
  assign H_readyN = w_ready;
  assign H_rsp    = w_rsp;

  // Burst type carries no meaning for a single-port memory.
`ifdef WAIT_STATE_EN
  assign w_unused = ^H_burst;
`else
  assign w_unused = ^{H_burst, (WAIT_CYCLES > 0)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_mem_slave
// Brief    : Scoreboard bench for ahb_lite_mem_slave. A pipelined driver
//            pushes each accepted transfer's expected response; a monitor
//            on the falling edge pops and compares on data-phase completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_mem_slave;

  localparam int WAIT_CYCLES = 2;
`ifdef WAIT_STATE_EN
  localparam int c_OK_WAITS = WAIT_CYCLES;
`else
  localparam int c_OK_WAITS = 0;
`endif

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  logic        H_clk   = 1'b0;
  logic        H_rstN  = 1'b0;
  logic        H_sel   = 1'b0;
  logic [31:0] H_add   = 32'h0;
  logic        H_WR    = 1'b0;
  logic [2:0]  H_size  = 3'b000;
  logic [3:0]  H_burst = 4'h0;
  logic [1:0]  H_trans = 2'b00;
  logic [31:0] W_data  = 32'h0;
  logic [31:0] R_data;
  logic        H_readyN;
  logic        H_rsp;

  ahb_lite_mem_slave #(
    .data_size   (32),
    .MEM_DEPTH   (256),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .H_clk    (H_clk),
    .H_rstN   (H_rstN),
    .H_sel    (H_sel),
    .H_add    (H_add),
    .H_WR     (H_WR),
    .H_size   (H_size),
    .H_burst  (H_burst),
    .H_trans  (H_trans),
    .W_data   (W_data),
    .R_data   (R_data),
    .H_readyN (H_readyN),
    .H_rsp    (H_rsp)
  );

  always #5 H_clk = ~H_clk;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    logic        rsp;
    string       name;
  } xfer_t;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    logic        rsp;
    string       name;
  } exp_t;

  xfer_t seq_q[$];
  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    mon_en   = 1'b0;
  bit    pending  = 1'b0;
  int    waits    = 0;
  exp_t  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void add(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                              input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                              input logic chk, input logic [31:0] exp, input logic rsp,
                              input string name);
    xfer_t t;
    t.sel = sel; t.trans = trans; t.addr = addr; t.wr = wr; t.size = size;
    t.wdata = wdata; t.chk = chk; t.exp = exp; t.rsp = rsp; t.name = name;
    seq_q.push_back(t);
  endfunction

  function automatic void wr_x(input string name, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] data);
    add(1'b1, 2'b10, addr, 1'b1, size, data, 1'b0, 32'h0, 1'b0, name);
  endfunction

  function automatic void rd_x(input string name, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] exp);
    add(1'b1, 2'b10, addr, 1'b0, size, 32'h0, 1'b1, exp, 1'b0, name);
  endfunction

  function automatic void er_x(input string name, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size);
    add(1'b1, 2'b10, addr, wr, size, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, name);
  endfunction

  function automatic void idle_x();
    add(1'b1, 2'b00, 32'h0, 1'b0, SZ_W, 32'h0, 1'b0, 32'h0, 1'b0, "idle");
  endfunction

  // Pipelined master: presents seq_q entries, holding them through wait states,
  // and drives W_data for whichever transfer is in its data phase.
  task automatic run_seq();
    int          i;
    int          budget;
    bit          in_data;
    bit          rdy;
    logic [31:0] cur_w;
    xfer_t       it;
    exp_t        e;
    i = 0; budget = 0; in_data = 1'b0; cur_w = 32'h0;
    while ((i < seq_q.size() || in_data) && budget < 1000) begin
      if (i < seq_q.size()) begin
        it = seq_q[i];
        H_sel = it.sel; H_trans = it.trans; H_add = it.addr;
        H_WR = it.wr; H_size = it.size; H_burst = 4'h1;
      end else begin
        H_sel = 1'b0; H_trans = 2'b00;
      end
      W_data = cur_w;
      @(negedge H_clk);
      rdy = H_readyN;
      @(posedge H_clk);
      if (rdy) begin
        in_data = 1'b0;
        if (i < seq_q.size()) begin
          if (it.sel && it.trans[1]) begin
            e.chk = it.chk; e.exp = it.exp; e.rsp = it.rsp; e.name = it.name;
            sb_q.push_back(e);
            cur_w   = it.wdata;
            in_data = 1'b1;
          end
          i++;
        end
      end
      #1;
      budget++;
    end
    if (budget >= 1000) begin
      n_checks++;
      n_errors++;
      $display("FAIL seq_timeout: actual=%0d cycles required<1000", budget);
    end
    H_sel = 1'b0; H_trans = 2'b00;
    seq_q.delete();
  endtask

  // Monitor: a transfer is accepted when ready, selected and NONSEQ/SEQ are
  // seen together; its response is checked when ready next comes back high.
  always @(negedge H_clk) begin
    if (!mon_en || !H_rstN) begin
      pending = 1'b0;
      waits   = 0;
    end else begin
      if (pending) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty: actual=0 entries required>=1");
          pending = 1'b0;
        end else if (H_readyN) begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_rsp"}, 32'(H_rsp), 32'(mon_e.rsp));
          check({mon_e.name, "_waits"}, 32'(waits), mon_e.rsp ? 32'd1 : 32'(c_OK_WAITS));
          if (mon_e.chk) check({mon_e.name, "_rdata"}, R_data, mon_e.exp);
          pending = 1'b0;
        end else begin
          waits++;
          check({sb_q[0].name, "_wait_rsp"}, 32'(H_rsp), 32'(sb_q[0].rsp));
          if (waits > 16) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_stall: actual=%0d waits required<=16", sb_q[0].name, waits);
            void'(sb_q.pop_front());
            pending = 1'b0;
          end
        end
      end
      if (H_readyN && H_sel && H_trans[1]) begin
        pending = 1'b1;
        waits   = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    H_rstN = 1'b0;
    repeat (3) @(posedge H_clk);
    @(negedge H_clk);
    check("rst_readyN", 32'(H_readyN), 32'd1);
    check("rst_rsp",    32'(H_rsp),    32'd0);
    check("rst_rdata",  R_data,        32'h0);
    @(posedge H_clk);
    #1;
    H_rstN = 1'b1;
    mon_en = 1'b1;

    // Word write, forwarded read, plain read, byte merge.
    wr_x("w10",   32'h10, SZ_W, 32'hDEADBEEF);
    rd_x("raw10", 32'h10, SZ_W, 32'hDEADBEEF);
    idle_x();
    rd_x("r10",   32'h10, SZ_W, 32'hDEADBEEF);
    wr_x("w10b",  32'h10, SZ_W, 32'h11223344);
    wr_x("wb13",  32'h13, SZ_B, 32'hAA5A5A5A);
    rd_x("rb13",  32'h10, SZ_W, 32'hAA223344);
    run_seq();

    // Halfword and byte lane updates.
    wr_x("w14",  32'h14, SZ_W, 32'hCAFEF00D);
    wr_x("wh16", 32'h16, SZ_H, 32'h55667788);
    wr_x("wh14", 32'h14, SZ_H, 32'h1234ABCD);
    wr_x("wb15", 32'h15, SZ_B, 32'h0000EE00);
    rd_x("r14",  32'h14, SZ_W, 32'h5566EECD);
    run_seq();

    // Out-of-range accesses error out and leave memory alone.
    wr_x("w00",    32'h0,   SZ_W, 32'h01020304);
    er_x("er400",  32'h400, 1'b0, SZ_W);
    er_x("ew400",  32'h400, 1'b1, SZ_W);
    rd_x("r00",    32'h0,   SZ_W, 32'h01020304);
    rd_x("r10_e",  32'h10,  SZ_W, 32'hAA223344);
    run_seq();

    // Misaligned and oversize accesses; NONSEQ in ERR2 is accepted.
    er_x("eh21",   32'h21, 1'b0, SZ_H);
    rd_x("r10_e2", 32'h10, SZ_W, 32'hAA223344);
    er_x("esz3",   32'h10, 1'b0, 3'b011);
    er_x("ew12",   32'h12, 1'b1, SZ_W);
    rd_x("rb13b",  32'h13, SZ_B, 32'hAA223344);
    run_seq();

    // Deselected and BUSY transfers are ignored; SEQ is accepted.
    add(1'b0, 2'b10, 32'h10, 1'b1, SZ_W, 32'h0, 1'b0, 32'h0, 1'b0, "nosel");
    add(1'b1, 2'b01, 32'h10, 1'b1, SZ_W, 32'h0, 1'b0, 32'h0, 1'b0, "busy");
    idle_x();
    rd_x("r10_ign", 32'h10, SZ_W, 32'hAA223344);
    add(1'b1, 2'b11, 32'h18, 1'b1, SZ_W, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, "wseq18");
    add(1'b1, 2'b11, 32'h18, 1'b0, SZ_W, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, "rseq18");
    wr_x("w3fc", 32'h3FC, SZ_W, 32'h13572468);
    rd_x("r3fc", 32'h3FC, SZ_W, 32'h13572468);
    wr_x("w20",  32'h20,  SZ_W, 32'h600DCAFE);
    rd_x("r20",  32'h20,  SZ_W, 32'h600DCAFE);
    run_seq();

    // Reset during the write's data/wait phase aborts the write.
    mon_en  = 1'b0;
    H_sel   = 1'b1; H_trans = 2'b10; H_add = 32'h20; H_WR = 1'b1; H_size = SZ_W;
    W_data  = 32'h0;
    @(posedge H_clk);
    #1;
    H_sel   = 1'b0; H_trans = 2'b00; W_data = 32'hBAD0BAD0;
    H_rstN  = 1'b0;
    @(posedge H_clk);
    #1;
    H_rstN  = 1'b1;
    @(negedge H_clk);
    check("midrst_readyN", 32'(H_readyN), 32'd1);
    check("midrst_rsp",    32'(H_rsp),    32'd0);
    check("midrst_rdata",  R_data,        32'h0);
    @(posedge H_clk);
    #1;
    mon_en = 1'b1;
    rd_x("r20_after_rst", 32'h20, SZ_W, 32'h600DCAFE);
    run_seq();

    repeat (2) @(posedge H_clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
